decoder_scanner: RTL and testbench



---
 rtl/decoder_scanner.sv | 172 +++++++++++++++++
 tb/tb_decoder_scanner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scanner.sv
// ---------------------------------------------------------------------------
// decoder_scanner
//   N-to-2**N one-hot row decoder with registered outputs. In manual mode it
//   decodes `in` one cycle late; in scan mode it walks every row in turn,
//   holding each for DWELL cycles followed by BLANK all-zero cycles. It drives
//   the row-select lines of the LED-matrix display.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   ena         global enable; 0 forces outputs low
//   mode        0 = manual decode, 1 = auto scan
//   in          manual row select (ignored in scan mode)
//   out         registered one-hot row drive
//   index       current row number
//   active      high whenever out is nonzero
//   row_start   one-cycle pulse on the first cycle of each scan row
//   frame_done  one-cycle pulse on the first cycle of row 0 after a wrap
//
// State | meaning
//   IDLE     | manual mode or disabled; scan not running
//   SHOW     | current scan row asserted, dwell timer running
//   BLANKING | gap between rows, outputs all zero
// ---------------------------------------------------------------------------
module decoder_scanner #(
    parameter int N     = 3,
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              mode,
    input  logic [N-1:0]      in,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      index,
    output logic              active,
    output logic              row_start,
    output logic              frame_done
);

    localparam int M  = 2**N;
    localparam int DW = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
    localparam int BW = ($clog2(BLANK + 1) < 1) ? 1 : $clog2(BLANK + 1);

    // Down-counters load count-1 so the terminal compare against zero lands
    // on the last cycle of the dwell/blank window.
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW     = 2'd1,
        BLANKING = 2'd2
    } state_t;

    state_t         state_q,      state_d;
    logic [M-1:0]   out_q,        out_d;
    logic [N-1:0]   index_q,      index_d;
    logic           active_q,     active_d;
    logic           row_start_q,  row_start_d;
    logic           frame_done_q, frame_done_d;
    logic [DW-1:0]  dwell_cnt_q,  dwell_cnt_d;
    logic [BW-1:0]  blank_cnt_q,  blank_cnt_d;

    logic [N-1:0]   next_row;
    logic           advance;

    assign next_row = index_q + N'(1);

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        index_d      = index_q;
        row_start_d  = 1'b0;
        frame_done_d = 1'b0;
        dwell_cnt_d  = dwell_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        advance      = 1'b0;

        if (!ena) begin
            state_d     = IDLE;
            out_d       = '0;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else if (!mode) begin
            state_d     = IDLE;
            out_d       = M'(1) << in;
            index_d     = in;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = SHOW;
                    index_d     = '0;
                    out_d       = M'(1);
                    row_start_d = 1'b1;
                    dwell_cnt_d = DWELL_LOAD;
                    blank_cnt_d = '0;
                end
                SHOW: begin
                    if (dwell_cnt_q == '0) begin
                        if (BLANK == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d     = BLANKING;
                            out_d       = '0;
                            blank_cnt_d = BLANK_LOAD;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DW'(1);
                    end
                end
                BLANKING: begin
                    if (blank_cnt_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        blank_cnt_d = blank_cnt_q - BW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                end
            endcase

            if (advance) begin
                state_d      = SHOW;
                index_d      = next_row;
                out_d        = M'(1) << next_row;
                row_start_d  = 1'b1;
                // Only a wrap reaches row 0 through this path; entry from
                // IDLE is handled above and never flags a completed frame.
                frame_done_d = (next_row == '0);
                dwell_cnt_d  = DWELL_LOAD;
                blank_cnt_d  = '0;
            end
        end

        active_d = |out_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_q        <= '0;
            index_q      <= '0;
            active_q     <= 1'b0;
            row_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dwell_cnt_q  <= '0;
            blank_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            index_q      <= index_d;
            active_q     <= active_d;
            row_start_q  <= row_start_d;
            frame_done_q <= frame_done_d;
            dwell_cnt_q  <= dwell_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
        end
    end

    assign out        = out_q;
    assign index      = index_q;
    assign active     = active_q;
    assign row_start  = row_start_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scanner.sv
// Scoreboard bench for decoder_scanner. Two instances: A (N=2, DWELL=3,
// BLANK=1) and B (N=3, DWELL=2, BLANK=0). Stimulus pushes the expected
// outputs for a given cycle; the monitor pops and compares at the negedge.
module tb_decoder_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A
    logic       a_rst = 1'b1, a_ena = 1'b1, a_mode = 1'b1;
    logic [1:0] a_in = '0;
    logic [3:0] a_out;
    logic [1:0] a_index;
    logic       a_active, a_row_start, a_frame_done;

    decoder_scanner #(.N(2), .DWELL(3), .BLANK(1)) dut_a (
        .clk(clk), .rst(a_rst), .ena(a_ena), .mode(a_mode), .in(a_in),
        .out(a_out), .index(a_index), .active(a_active),
        .row_start(a_row_start), .frame_done(a_frame_done)
    );

    // Instance B
    logic       b_rst = 1'b1, b_ena = 1'b1, b_mode = 1'b1;
    logic [2:0] b_in = '0;
    logic [7:0] b_out;
    logic [2:0] b_index;
    logic       b_active, b_row_start, b_frame_done;

    decoder_scanner #(.N(3), .DWELL(2), .BLANK(0)) dut_b (
        .clk(clk), .rst(b_rst), .ena(b_ena), .mode(b_mode), .in(b_in),
        .out(b_out), .index(b_index), .active(b_active),
        .row_start(b_row_start), .frame_done(b_frame_done)
    );

    typedef struct {
        int         cyc;
        bit         dut_b;
        logic [7:0] out;
        logic [2:0] idx;
        logic       act;
        logic       rs;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req);
        end
    endtask

    // Expectation for the outputs after the next rising edge.
    task automatic expect_a(input logic [3:0] o, input logic [1:0] i, input logic ac, input logic rs, input logic fd);
        exp_t e;
        e.cyc = cyc + 1; e.dut_b = 1'b0; e.out = {4'b0, o}; e.idx = {1'b0, i};
        e.act = ac; e.rs = rs; e.fd = fd;
        exp_q.push_back(e);
    endtask

    task automatic expect_b(input logic [7:0] o, input logic [2:0] i, input logic ac, input logic rs, input logic fd);
        exp_t e;
        e.cyc = cyc + 1; e.dut_b = 1'b1; e.out = o; e.idx = i;
        e.act = ac; e.rs = rs; e.fd = fd;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("a_onehot", cyc, ($countones(a_out) <= 1), 1);
            chk("b_onehot", cyc, ($countones(b_out) <= 1), 1);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sched", cyc, e.cyc, cyc);
            if (!e.dut_b) begin
                chk("a_out",        cyc, {28'b0, a_out},        {24'b0, e.out});
                chk("a_index",      cyc, {30'b0, a_index},      {29'b0, e.idx});
                chk("a_active",     cyc, {31'b0, a_active},     {31'b0, e.act});
                chk("a_row_start",  cyc, {31'b0, a_row_start},  {31'b0, e.rs});
                chk("a_frame_done", cyc, {31'b0, a_frame_done}, {31'b0, e.fd});
            end else begin
                chk("b_out",        cyc, {24'b0, b_out},        {24'b0, e.out});
                chk("b_index",      cyc, {29'b0, b_index},      {29'b0, e.idx});
                chk("b_active",     cyc, {31'b0, b_active},     {31'b0, e.act});
                chk("b_row_start",  cyc, {31'b0, b_row_start},  {31'b0, e.rs});
                chk("b_frame_done", cyc, {31'b0, b_frame_done}, {31'b0, e.fd});
            end
        end
    end

    // Hand-written scan sequence for A: 3 show cycles, 1 blank, per row.
    logic [3:0] scan_out [26] = '{4'h1,4'h1,4'h1,4'h0, 4'h2,4'h2,4'h2,4'h0,
                                  4'h4,4'h4,4'h4,4'h0, 4'h8,4'h8,4'h8,4'h0,
                                  4'h1,4'h1,4'h1,4'h0, 4'h2,4'h2,4'h2,4'h0,
                                  4'h4,4'h4};
    logic [1:0] scan_idx [26] = '{2'd0,2'd0,2'd0,2'd0, 2'd1,2'd1,2'd1,2'd1,
                                  2'd2,2'd2,2'd2,2'd2, 2'd3,2'd3,2'd3,2'd3,
                                  2'd0,2'd0,2'd0,2'd0, 2'd1,2'd1,2'd1,2'd1,
                                  2'd2,2'd2};

    initial begin
        // Reset held for two edges with ena=1, mode=1
        expect_a(4'h0, 2'd0, 0, 0, 0); tick();
        expect_a(4'h0, 2'd0, 0, 0, 0); tick();

        // Manual truth table
        a_rst = 1'b0; a_mode = 1'b0; a_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in = 2'(i);
            expect_a(4'(1 << i), 2'(i), 1, 0, 0); tick();
        end
        a_ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in = 2'(i);
            expect_a(4'h0, 2'd3, 0, 0, 0); tick();
        end

        // Scan from IDLE through one full frame and into row 2
        a_mode = 1'b1; a_ena = 1'b1;
        for (int k = 0; k < 26; k++) begin
            expect_a(scan_out[k], scan_idx[k], (scan_out[k] != 4'h0),
                     (k % 4 == 0), (k == 16));
            tick();
        end

        // Disable during row 2 show cycle 2, then re-enable
        a_ena = 1'b0;
        expect_a(4'h0, 2'd2, 0, 0, 0); tick();
        expect_a(4'h0, 2'd2, 0, 0, 0); tick();
        a_ena = 1'b1;
        expect_a(4'h1, 2'd0, 1, 1, 0); tick();
        expect_a(4'h1, 2'd0, 1, 0, 0); tick();
        expect_a(4'h1, 2'd0, 1, 0, 0); tick();
        expect_a(4'h0, 2'd0, 0, 0, 0); tick();
        expect_a(4'h2, 2'd1, 1, 1, 0); tick();

        // Mode switch while scanning row 1
        a_mode = 1'b0; a_in = 2'd3;
        expect_a(4'h8, 2'd3, 1, 0, 0); tick();
        a_mode = 1'b1;
        expect_a(4'h1, 2'd0, 1, 1, 0); tick();
        expect_a(4'h1, 2'd0, 1, 0, 0); tick();

        // Instance B: no blanking, two-cycle dwell, eight rows
        a_ena = 1'b0;
        b_rst = 1'b0; b_ena = 1'b1; b_mode = 1'b1;
        for (int k = 0; k < 37; k++) begin
            expect_b(8'(1 << ((k / 2) % 8)), 3'((k / 2) % 8), 1,
                     (k % 2 == 0), (k == 16 || k == 32));
            tick();
        end
        b_rst = 1'b1;
        expect_b(8'h00, 3'd0, 0, 0, 0); tick();
        b_rst = 1'b0;
        expect_b(8'h01, 3'd0, 1, 1, 0); tick();
        expect_b(8'h01, 3'd0, 1, 0, 0); tick();
        expect_b(8'h02, 3'd1, 1, 1, 0); tick();

        @(negedge clk);
        #1;
        chk("queue_drained", cyc, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
